// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder:
// RV32I load/store width codes, FSM states and the captured request bundle.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  funct3;
    } dmem_req_t;

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr[1:0]
// and sign- or zero-extends it according to the RV32I load width code.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word_i >> {addr_i, 3'b000});
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with fixed access latency,
// byte-lane stores, aligned/extended loads and error reporting.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem_q [DEPTH_WORDS];

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic          oob;
    logic          misalign;
    logic          illegal;
    logic          err;
    logic          commit;
    logic [IW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;

    assign oob = {2'b00, req_q.addr[31:2]} >= 32'(DEPTH_WORDS);
    assign idx = req_q.addr[IW+1:2];

    always_comb begin
        misalign = 1'b0;
        case (req_q.funct3[1:0])
            2'b01:   misalign = req_q.addr[0];
            2'b10:   misalign = |req_q.addr[1:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        if (req_q.write)
            illegal = !(req_q.funct3 inside {F3_SB, F3_SH, F3_SW});
        else
            illegal = !(req_q.funct3 inside
                        {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end

    assign err     = oob | misalign | illegal;
    assign rd_word = oob ? 32'h0 : mem_q[idx];
    // Stores land on the last access edge; reset forces IDLE so an
    // aborted store can never reach this point.
    assign commit  = (state_q == WAIT) && (cnt_q == 4'd0)
                   && req_q.write && !err;

    load_align u_load_align (
        .word_i   (rd_word),
        .addr_i   (req_q.addr[1:0]),
        .funct3_i (req_q.funct3),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (req_q.be[i])
                    mem_q[idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.write  = req_write;
                    req_d.addr   = req_addr;
                    req_d.wdata  = req_wdata;
                    req_d.be     = req_byte_en;
                    req_d.funct3 = req_funct3;
                    cnt_d        = 4'(WAIT_CYCLES - 1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    err_d   = err;
                    rdata_d = (err || req_q.write) ? 32'h0 : ld_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array
// reference model, plus directed latency, backpressure and reset scenarios.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int W     = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byte_en;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks;
    int failures;

    logic [31:0] mdl [DEPTH];

    typedef struct {
        bit        wr;
        bit [31:0] a;
        bit [31:0] wd;
        bit [3:0]  be;
        bit [2:0]  f3;
        bit [31:0] erd;
        bit        eerr;
    } vec_t;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .req_funct3  (req_funct3),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ref_op(input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [2:0] f3,
                          output logic [31:0] exp_rd, output logic exp_err);
        int unsigned w;
        int unsigned sz;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        w      = a >> 2;
        sz     = 1 << f3[1:0];
        exp_rd = 32'h0;
        exp_err = (w >= DEPTH) || ((a % sz) != 0) ||
                  (wr ? (f3 > 3'd2) : (f3 == 3 || f3 == 6 || f3 == 7));
        if (exp_err) return;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
            return;
        end
        word = mdl[w];
        b = 8'(word >> (8 * (a % 4)));
        h = 16'(word >> (16 * ((a / 2) % 2)));
        case (f3)
            3'd0: exp_rd = 32'($signed(b));
            3'd1: exp_rd = 32'($signed(h));
            3'd2: exp_rd = word;
            3'd4: exp_rd = {24'h0, b};
            3'd5: exp_rd = {16'h0, h};
            default: exp_rd = 32'h0;
        endcase
    endtask

    task automatic do_req(input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [2:0] f3,
                          output logic [31:0] rd, output logic er,
                          output int lat);
        int g;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        resp_ready  = 1'b1;
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = a;
        req_wdata   = wd;
        req_byte_en = be;
        req_funct3  = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_byte_en = '0;
        req_funct3  = '0;
        resp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp_data got=%h/%b exp=0/0",
                     resp_rdata, resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        logic [31:0] rd, erd, wd;
        logic        er, eer;
        int          lat;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            ref_op(1'b1, 32'(i * 4), wd, 4'hF, 3'd2, erd, eer);
            do_req(1'b1, 32'(i * 4), wd, 4'hF, 3'd2, rd, er, lat);
            checks++;
            if (er !== 1'b0 || rd !== 32'h0 || lat != W + 1) begin
                failures++;
                $display("FAIL fill_sw[%0d] got=%h/%b lat=%0d exp=0/0 lat=%0d",
                         i, rd, er, lat, W + 1);
            end
        end
    endtask

    task automatic test_directed;
        vec_t        v[$];
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;
        v.push_back('{1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 32'h0, 0});
        v.push_back('{0, 32'h10, 32'h0, 4'h0, 3'd2, 32'hDEADBEEF, 0});
        v.push_back('{1, 32'h20, 32'h0, 4'hF, 3'd2, 32'h0, 0});
        v.push_back('{1, 32'h21, 32'h80808080, 4'b0010, 3'd0, 32'h0, 0});
        v.push_back('{0, 32'h21, 32'h0, 4'h0, 3'd0, 32'hFFFFFF80, 0});
        v.push_back('{0, 32'h21, 32'h0, 4'h0, 3'd4, 32'h00000080, 0});
        v.push_back('{0, 32'h20, 32'h0, 4'h0, 3'd2, 32'h00008000, 0});
        v.push_back('{0, 32'h13, 32'h0, 4'h0, 3'd1, 32'h0, 1});
        v.push_back('{1, 32'h22, 32'hFFFFFFFF, 4'hF, 3'd2, 32'h0, 1});
        v.push_back('{0, 32'h20, 32'h0, 4'h0, 3'd2, 32'h00008000, 0});
        v.push_back('{0, 32'(4 * DEPTH), 32'h0, 4'h0, 3'd2, 32'h0, 1});
        v.push_back('{1, 32'h20, 32'hFFFFFFFF, 4'h0, 3'd2, 32'h0, 0});
        v.push_back('{0, 32'h20, 32'h0, 4'h0, 3'd2, 32'h00008000, 0});
        v.push_back('{0, 32'h20, 32'h0, 4'h0, 3'd3, 32'h0, 1});
        v.push_back('{1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'd4, 32'h0, 1});
        v.push_back('{0, 32'h20, 32'h0, 4'h0, 3'd1, 32'hFFFF8000, 0});
        v.push_back('{0, 32'h20, 32'h0, 4'h0, 3'd5, 32'h00008000, 0});
        v.push_back('{0, 32'h22, 32'h0, 4'h0, 3'd1, 32'h00000000, 0});
        foreach (v[k]) begin
            ref_op(v[k].wr, v[k].a, v[k].wd, v[k].be, v[k].f3, erd, eer);
            do_req(v[k].wr, v[k].a, v[k].wd, v[k].be, v[k].f3, rd, er, lat);
            checks++;
            if (rd !== v[k].erd || er !== v[k].eerr) begin
                failures++;
                $display("FAIL directed[%0d] got=%h/%b exp=%h/%b",
                         k, rd, er, v[k].erd, v[k].eerr);
            end
            checks++;
            if (lat != W + 1) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d",
                         k, lat, W + 1);
            end
        end
    endtask

    task automatic test_random;
        logic        wr, er, eer;
        logic [31:0] a, wd, rd, erd;
        logic [3:0]  be;
        logic [2:0]  f3;
        int          lat;
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            a  = 32'($urandom_range(0, DEPTH + 3) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            wd = $urandom;
            be = 4'($urandom);
            f3 = 3'($urandom);
            ref_op(wr, a, wd, be, f3, erd, eer);
            do_req(wr, a, wd, be, f3, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat != W + 1) begin
                failures++;
                $display("FAIL random[%0d] wr=%b a=%h f3=%0d got=%h/%b lat=%0d exp=%h/%b",
                         n, wr, a, f3, rd, er, lat, erd, eer);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] e1, e2;
        logic        ee1, ee2;
        int          n;
        ref_op(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, e1, ee1);
        ref_op(1'b0, 32'h24, 32'h0, 4'h0, 3'd2, e2, ee2);
        @(negedge clk);
        resp_ready  = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = 32'h10;
        req_byte_en = 4'h0;
        req_funct3  = 3'd2;
        @(posedge clk);
        #1;
        req_addr = 32'h24;
        n = 1;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (resp_rdata !== e1 || resp_err !== ee1 || n != W + 1) begin
            failures++;
            $display("FAIL bp_first got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                     resp_rdata, resp_err, n, e1, ee1, W + 1);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp_rdata !== e1 || resp_err !== ee1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b rdy=%b d=%h e=%b exp v=1 rdy=0 d=%h e=%b",
                         c, resp_valid, req_ready, resp_rdata, resp_err, e1, ee1);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1",
                     resp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accept got rdy=%b exp=0", req_ready);
        end
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (resp_rdata !== e2 || resp_err !== ee2 || n != W + 1) begin
            failures++;
            $display("FAIL bp_second got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                     resp_rdata, resp_err, n, e2, ee2, W + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        logic [31:0] erd, rd;
        logic        eer, er;
        int          lat;
        @(negedge clk);
        resp_ready  = 1'b1;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 32'h30;
        req_wdata   = 32'h12345678;
        req_byte_en = 4'hF;
        req_funct3  = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_wait got rdy=%b exp=0", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 ||
            resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got v=%b rdy=%b d=%h e=%b exp v=0 rdy=1 d=0 e=0",
                     resp_valid, req_ready, resp_rdata, resp_err);
        end
        repeat (W + 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_op(1'b0, 32'h30, 32'h0, 4'h0, 3'd2, erd, eer);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== erd || er !== eer) begin
            failures++;
            $display("FAIL abort_readback got=%h/%b exp=%h/%b", rd, er, erd, eer);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of internal storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, access cycles between request accept and response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address (data_addr from ALU).
REQ-009 SHALL have port req_wdata  input  32  store data, already lane-replicated.
REQ-010 SHALL have port req_byte_en  input  4  store lane enables, already shifted by addr[1:0].
REQ-011 SHALL have port req_funct3  input  3  RV32I load/store width code.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port resp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  request was misaligned, out of range or illegal funct3.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL capture all req_* fields on req_valid & req_ready and go IDLE->WAIT, loading wait counter with WAIT_CYCLES-1.
REQ-018 SHALL decrement the counter each WAIT cycle and go WAIT->RESP when the counter is 0, committing stores and reading load data on that final WAIT edge.
REQ-019 SHALL hold resp_valid = 1, resp_rdata and resp_err stable in RESP until resp_ready = 1, then go RESP->IDLE; request-to-response latency is WAIT_CYCLES+1 clocks.
REQ-020 SHALL write byte lane i of word req_addr[31:2] from req_wdata[8i+7:8i] only if req_byte_en[i] = 1; store with req_byte_en = 0 writes nothing, no error.
REQ-021 SHALL return loads per funct3: 000 LB sign-extended byte at addr[1:0]; 001 LH sign-extended half at addr[1]; 010 LW; 100 LBU zero-extended; 101 LHU zero-extended.
REQ-022 SHALL flag resp_err = 1, suppress write and return rdata 0 for: halfword with addr[0] = 1; word with addr[1:0] != 0; req_addr[31:2] >= DEPTH_WORDS; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-023 SHALL ignore req_valid outside IDLE (no queuing); a request held across RESP is accepted in the first following IDLE cycle.
REQ-024 SHALL return the newly written value for a load following a store to the same word (no stale read).

Reset
REQ-025 SHALL, while rst_n = 0, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1.
REQ-026 SHALL abort an in-flight request on reset assertion in WAIT or RESP; a store not yet committed SHALL NOT be written.
REQ-027 SHALL NOT reset storage contents.

Structure
REQ-028 SHALL place funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum in shared package dmem_pkg.
REQ-029 SHALL implement lane select plus sign/zero extension in combinational sub-module load_align (inputs word, addr[1:0], funct3; output 32-bit data).
REQ-030 SHALL hold storage as an internal word array with per-byte write enables.

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF be 4'b1111, then LW 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid exactly WAIT_CYCLES+1 clocks after accept.
REQ-032 SB addr 0x21 wdata 0x80808080 be 4'b0010 over word 0; LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 -> 0x00008000.
REQ-033 LH 0x13 -> resp_err 1, rdata 0; SW 0x22 -> resp_err 1 and LW 0x20 unchanged; LW 4*DEPTH_WORDS -> resp_err 1.
REQ-034 Hold resp_ready 0 for 5 clocks in RESP with req_valid 1 -> resp fields stable, req_ready 0, second request accepted only after response handshake.
REQ-035 Assert rst_n = 0 during WAIT of SW 0x30 data 0x12345678 -> resp_valid 0 immediately, FSM IDLE; later LW 0x30 returns prior contents.
